// File: rtl/if_prefetch_unit_if.sv
// if_prefetch_unit_if: instruction-memory request/response and decode-side signals of the fetch front end
interface if_prefetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus1;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc_plus1,
        input  imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, stall
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc_plus1,
        output imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, stall
    );
endinterface

// File: rtl/if_prefetch_unit.sv
// if_prefetch_unit: fetch PC, variable-latency imem requests and in-order prefetch queue feeding IF/ID
module if_prefetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input logic               clk,
    input logic               rst,
    if_prefetch_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc1 [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic          accept;
    logic          rsp;
    logic          push;
    logic          pop;

    // Queue space is reserved at request time, so a response can always be pushed.
    always_comb begin
        bus.imem_req    = rst && !bus.redirect && ({1'b0, count} + {1'b0, outstanding} < LIMIT);
        bus.imem_addr   = fetch_pc;
        bus.id_valid    = count != '0;
        bus.id_instr    = count != '0 ? q_instr[rd_ptr] : '0;
        bus.id_pc_plus1 = count != '0 ? q_pc1[rd_ptr] : '0;
        accept          = bus.imem_req && bus.imem_ready;
        rsp             = bus.imem_rvalid && outstanding != '0;
        push            = rsp && drop_cnt == '0 && !bus.redirect;
        pop             = count != '0 && !bus.stall && !bus.redirect;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (bus.redirect) begin
            fetch_pc    <= bus.redirect_pc;
            resp_pc     <= bus.redirect_pc;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= outstanding - CW'(rsp);
            drop_cnt    <= outstanding - CW'(rsp);
        end else begin
            fetch_pc    <= accept ? fetch_pc + 32'd1 : fetch_pc;
            resp_pc     <= push ? resp_pc + 32'd1 : resp_pc;
            rd_ptr      <= rd_ptr + AW'(pop);
            wr_ptr      <= wr_ptr + AW'(push);
            count       <= count + CW'(push) - CW'(pop);
            outstanding <= outstanding + CW'(accept) - CW'(rsp);
            drop_cnt    <= drop_cnt - CW'(rsp && drop_cnt != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= bus.imem_rdata;
            q_pc1[wr_ptr]   <= resp_pc + 32'd1;
        end
    end
endmodule
